// File: rtl/slc3_control_pkg.sv
// Shared types and encodings for the SLC-3 control unit: opcodes, ALU ops,
// mux select encodings and FSM state codes.
package slc3_control_pkg;

  typedef logic [3:0] lc3b_opcode;
  typedef logic [1:0] lc3b_aluop;
  typedef logic [3:0] lc3b_ctrl_state;

  localparam lc3b_opcode op_br  = 4'b0000;
  localparam lc3b_opcode op_add = 4'b0001;
  localparam lc3b_opcode op_and = 4'b0101;
  localparam lc3b_opcode op_not = 4'b1001;
  localparam lc3b_opcode op_ldr = 4'b0110;
  localparam lc3b_opcode op_str = 4'b0111;
  localparam lc3b_opcode op_jmp = 4'b1100;
  localparam lc3b_opcode op_pse = 4'b1101;

  localparam lc3b_aluop alu_add  = 2'b00;
  localparam lc3b_aluop alu_and  = 2'b01;
  localparam lc3b_aluop alu_not  = 2'b10;
  localparam lc3b_aluop alu_pass = 2'b11;

  typedef enum logic [1:0] {
    PCMUX_BUS   = 2'b00,
    PCMUX_INC   = 2'b01,
    PCMUX_ADDER = 2'b10
  } pcmux_sel_e;

  typedef enum logic [1:0] {
    ADDR2_ZERO  = 2'b00,
    ADDR2_OFF6  = 2'b01,
    ADDR2_OFF9  = 2'b10,
    ADDR2_OFF11 = 2'b11
  } addr2_sel_e;

  localparam lc3b_ctrl_state S_HALT = 4'd0;
  localparam lc3b_ctrl_state F1     = 4'd1;
  localparam lc3b_ctrl_state F2     = 4'd2;
  localparam lc3b_ctrl_state F3     = 4'd3;
  localparam lc3b_ctrl_state DEC    = 4'd4;
  localparam lc3b_ctrl_state ALU    = 4'd5;
  localparam lc3b_ctrl_state BR_T   = 4'd6;
  localparam lc3b_ctrl_state JMP    = 4'd7;
  localparam lc3b_ctrl_state LD1    = 4'd8;
  localparam lc3b_ctrl_state LD2    = 4'd9;
  localparam lc3b_ctrl_state LD3    = 4'd10;
  localparam lc3b_ctrl_state ST1    = 4'd11;
  localparam lc3b_ctrl_state ST2    = 4'd12;
  localparam lc3b_ctrl_state ST3    = 4'd13;
  localparam lc3b_ctrl_state PSE1   = 4'd14;
  localparam lc3b_ctrl_state PSE2   = 4'd15;

endpackage

// File: rtl/slc3_control_if.sv
// Control <-> datapath/SRAM signal bundle. The master modport is the control
// FSM side; the slave modport is the datapath side.
interface slc3_control_if;
  import slc3_control_pkg::*;

  logic       Run;
  logic       Continue;
  lc3b_opcode opcode;
  logic       BEN;
  logic       imm5_sel;

  logic       load_ir;
  logic       load_pc;
  logic       load_mdr;
  logic       load_mar;
  logic       ld_reg;
  logic       GatePC;
  logic       GateMDR;
  logic       GateALU;
  logic       GateMARMUX;
  logic [1:0] pc_sel;
  logic       addr1mux_sel;
  logic [1:0] addr2mux_sel;
  logic       SR2_mux_sel;
  logic       sr1_sel;
  lc3b_aluop  ALUK;
  logic       Mem_CE;
  logic       Mem_OE;
  logic       Mem_WE;

  modport master (
    input  Run, Continue, opcode, BEN, imm5_sel,
    output load_ir, load_pc, load_mdr, load_mar, ld_reg,
           GatePC, GateMDR, GateALU, GateMARMUX,
           pc_sel, addr1mux_sel, addr2mux_sel, SR2_mux_sel, sr1_sel, ALUK,
           Mem_CE, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, opcode, BEN, imm5_sel,
    input  load_ir, load_pc, load_mdr, load_mar, ld_reg,
           GatePC, GateMDR, GateALU, GateMARMUX,
           pc_sel, addr1mux_sel, addr2mux_sel, SR2_mux_sel, sr1_sel, ALUK,
           Mem_CE, Mem_OE, Mem_WE
  );

endinterface

// File: rtl/slc3_wait_ctr.sv
// Memory wait counter: restarts at zero on clear, done when the current
// memory state has been held MEM_WAIT cycles.
module slc3_wait_ctr #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic done
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = clear ? 4'd0 : count_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= 4'd0;
    else        count_q <= count_d;
  end

  assign done = (count_q == 4'(MEM_WAIT - 1));

endmodule

// File: rtl/slc3_control.sv
// SLC-3 Moore control FSM (fetch/decode/execute). Define SLC3_PAUSE_EN to
// include the PSE1/PSE2 pause states; otherwise opcode 1101 is a NOP.
module slc3_control
  import slc3_control_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic           Clk,
  input  logic           Reset,
  slc3_control_if.master bus
);

  lc3b_ctrl_state state_q;
  lc3b_ctrl_state state_d;
  logic           wait_done;

`ifndef SLC3_PAUSE_EN
  logic unused_continue;
  assign unused_continue = bus.Continue;
`endif

  // Any state change restarts the counter, so each memory state starts at 0.
  slc3_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk   (Clk),
    .rst_n (Reset),
    .clear (state_d != state_q),
    .done  (wait_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT: if (bus.Run) state_d = F1;
      F1:     state_d = F2;
      F2:     if (wait_done) state_d = F3;
      F3:     state_d = DEC;
      DEC: begin
        case (bus.opcode)
          op_add, op_and, op_not: state_d = ALU;
          op_br:  state_d = bus.BEN ? BR_T : F1;
          op_jmp: state_d = JMP;
          op_ldr: state_d = LD1;
          op_str: state_d = ST1;
`ifdef SLC3_PAUSE_EN
          op_pse: state_d = PSE1;
`else
          op_pse: state_d = F1;
`endif
          default: state_d = F1;
        endcase
      end
      ALU, BR_T, JMP, LD3: state_d = F1;
      LD1: state_d = LD2;
      LD2: if (wait_done) state_d = LD3;
      ST1: state_d = ST2;
      ST2: state_d = ST3;
      ST3: if (wait_done) state_d = F1;
      PSE1: begin
`ifdef SLC3_PAUSE_EN
        if (bus.Continue) state_d = PSE2;
`else
        state_d = F1;
`endif
      end
      PSE2: begin
`ifdef SLC3_PAUSE_EN
        if (!bus.Continue) state_d = F1;
`else
        state_d = F1;
`endif
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= S_HALT;
    else        state_q <= state_d;
  end

  // Outputs depend on the registered state; opcode/imm5 come from the IR.
  always_comb begin
    bus.load_ir      = 1'b0;
    bus.load_pc      = 1'b0;
    bus.load_mdr     = 1'b0;
    bus.load_mar     = 1'b0;
    bus.ld_reg       = 1'b0;
    bus.GatePC       = 1'b0;
    bus.GateMDR      = 1'b0;
    bus.GateALU      = 1'b0;
    bus.GateMARMUX   = 1'b0;
    bus.pc_sel       = PCMUX_BUS;
    bus.addr1mux_sel = 1'b0;
    bus.addr2mux_sel = ADDR2_ZERO;
    bus.SR2_mux_sel  = 1'b0;
    bus.sr1_sel      = 1'b0;
    bus.ALUK         = alu_add;
    bus.Mem_CE       = 1'b1;
    bus.Mem_OE       = 1'b1;
    bus.Mem_WE       = 1'b1;
    case (state_q)
      F1: begin
        bus.GatePC   = 1'b1;
        bus.load_mar = 1'b1;
        bus.pc_sel   = PCMUX_INC;
        bus.load_pc  = 1'b1;
      end
      F2, LD2: begin
        bus.Mem_CE   = 1'b0;
        bus.Mem_OE   = 1'b0;
        bus.load_mdr = 1'b1;
      end
      F3: begin
        bus.GateMDR = 1'b1;
        bus.load_ir = 1'b1;
      end
      ALU: begin
        bus.GateALU     = 1'b1;
        bus.ld_reg      = 1'b1;
        bus.SR2_mux_sel = bus.imm5_sel;
        case (bus.opcode)
          op_and:  bus.ALUK = alu_and;
          op_not:  bus.ALUK = alu_not;
          default: bus.ALUK = alu_add;
        endcase
      end
      BR_T: begin
        bus.addr2mux_sel = ADDR2_OFF9;
        bus.pc_sel       = PCMUX_ADDER;
        bus.load_pc      = 1'b1;
      end
      JMP: begin
        bus.addr1mux_sel = 1'b1;
        bus.pc_sel       = PCMUX_ADDER;
        bus.load_pc      = 1'b1;
      end
      LD1, ST1: begin
        bus.addr1mux_sel = 1'b1;
        bus.addr2mux_sel = ADDR2_OFF6;
        bus.GateMARMUX   = 1'b1;
        bus.load_mar     = 1'b1;
      end
      LD3: begin
        bus.GateMDR = 1'b1;
        bus.ld_reg  = 1'b1;
      end
      ST2: begin
        bus.sr1_sel  = 1'b1;
        bus.ALUK     = alu_pass;
        bus.GateALU  = 1'b1;
        bus.load_mdr = 1'b1;
      end
      ST3: begin
        bus.Mem_CE  = 1'b0;
        bus.Mem_WE  = 1'b0;
        bus.GateMDR = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_slc3_control.sv
// Directed self-checking bench for slc3_control; honours SLC3_PAUSE_EN.
module tb_slc3_control;
  import slc3_control_pkg::*;

  localparam int MW = 2;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  slc3_control_if bus ();

  slc3_control #(.MEM_WAIT(MW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic int gate_count();
    return int'(bus.GatePC) + int'(bus.GateMDR) + int'(bus.GateALU) + int'(bus.GateMARMUX);
  endfunction

  function automatic int load_count();
    return int'(bus.load_ir) + int'(bus.load_pc) + int'(bus.load_mdr) +
           int'(bus.load_mar) + int'(bus.ld_reg);
  endfunction

  // Expects to be called while sampling F1; returns while sampling DEC.
  task automatic fetch_to_dec(input string tag);
    int oe_cycles;
    checks++;
    if (!(bus.GatePC === 1'b1 && bus.load_mar === 1'b1 && bus.load_pc === 1'b1 &&
          bus.pc_sel === 2'b01 && gate_count() == 1)) begin
      errors++;
      $display("[TB] FAIL %s_f1 GatePC=%b load_mar=%b load_pc=%b pc_sel=%b gates=%0d expected 1 1 1 01 1",
               tag, bus.GatePC, bus.load_mar, bus.load_pc, bus.pc_sel, gate_count());
    end
    tick;
    oe_cycles = 0;
    while (bus.Mem_OE === 1'b0 && oe_cycles < 20) begin
      if (bus.Mem_CE !== 1'b0 || bus.load_mdr !== 1'b1 || gate_count() != 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s_f2 CE=%b load_mdr=%b gates=%0d expected 0 1 0",
                 tag, bus.Mem_CE, bus.load_mdr, gate_count());
      end
      oe_cycles++;
      tick;
    end
    checks++;
    if (oe_cycles != MW) begin
      errors++;
      $display("[TB] FAIL %s_fetch_oe_cycles got %0d expected %0d", tag, oe_cycles, MW);
    end
    checks++;
    if (!(bus.GateMDR === 1'b1 && bus.load_ir === 1'b1 && gate_count() == 1)) begin
      errors++;
      $display("[TB] FAIL %s_f3 GateMDR=%b load_ir=%b expected 1 1", tag, bus.GateMDR, bus.load_ir);
    end
    tick;
    checks++;
    if (load_count() != 0 || gate_count() != 0 || bus.Mem_CE !== 1'b1 || dut.state_q !== DEC) begin
      errors++;
      $display("[TB] FAIL %s_dec loads=%0d gates=%0d CE=%b state=%0d expected 0 0 1 %0d",
               tag, load_count(), gate_count(), bus.Mem_CE, dut.state_q, DEC);
    end
  endtask

  task automatic expect_f1(input string tag);
    checks++;
    if (dut.state_q !== F1 || bus.GatePC !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_back_to_f1 state=%0d GatePC=%b expected %0d 1", tag, dut.state_q, bus.GatePC, F1);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    tick;
    Reset = 1'b1;
    tick;
    checks++;
    if (dut.state_q !== S_HALT || load_count() != 0 || gate_count() != 0 ||
        bus.Mem_CE !== 1'b1 || bus.Mem_OE !== 1'b1 || bus.Mem_WE !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_defaults state=%0d loads=%0d gates=%0d CE/OE/WE=%b%b%b expected 0 0 0 111",
               dut.state_q, load_count(), gate_count(), bus.Mem_CE, bus.Mem_OE, bus.Mem_WE);
    end
    bus.Run = 1'b1;
    tick;
    bus.Run = 1'b0;
    expect_f1("run");
  endtask

  task automatic test_alu;
    bus.opcode = op_add;
    bus.imm5_sel = 1'b1;
    fetch_to_dec("add");
    tick;
    checks++;
    if (!(bus.GateALU === 1'b1 && bus.ld_reg === 1'b1 && bus.SR2_mux_sel === 1'b1 &&
          bus.ALUK === 2'b00 && gate_count() == 1)) begin
      errors++;
      $display("[TB] FAIL add_alu GateALU=%b ld_reg=%b SR2=%b ALUK=%b expected 1 1 1 00",
               bus.GateALU, bus.ld_reg, bus.SR2_mux_sel, bus.ALUK);
    end
    tick;
    expect_f1("add");

    bus.opcode = op_and;
    bus.imm5_sel = 1'b0;
    fetch_to_dec("and");
    tick;
    checks++;
    if (bus.ALUK !== 2'b01 || bus.SR2_mux_sel !== 1'b0 || bus.ld_reg !== 1'b1) begin
      errors++;
      $display("[TB] FAIL and_alu ALUK=%b SR2=%b ld_reg=%b expected 01 0 1", bus.ALUK, bus.SR2_mux_sel, bus.ld_reg);
    end
    tick;

    bus.opcode = op_not;
    fetch_to_dec("not");
    tick;
    checks++;
    if (bus.ALUK !== 2'b10 || bus.GateALU !== 1'b1) begin
      errors++;
      $display("[TB] FAIL not_alu ALUK=%b GateALU=%b expected 10 1", bus.ALUK, bus.GateALU);
    end
    tick;
    expect_f1("not");
  endtask

  task automatic test_branch;
    bus.opcode = op_br;
    bus.BEN = 1'b0;
    fetch_to_dec("br_nt");
    tick;
    expect_f1("br_nt");
    bus.BEN = 1'b1;
    fetch_to_dec("br_t");
    tick;
    checks++;
    if (!(bus.load_pc === 1'b1 && bus.pc_sel === 2'b10 && bus.addr2mux_sel === 2'b10 &&
          bus.addr1mux_sel === 1'b0 && gate_count() == 0)) begin
      errors++;
      $display("[TB] FAIL br_taken load_pc=%b pc_sel=%b addr2=%b addr1=%b expected 1 10 10 0",
               bus.load_pc, bus.pc_sel, bus.addr2mux_sel, bus.addr1mux_sel);
    end
    bus.BEN = 1'b0;
    tick;
    expect_f1("br_t");

    bus.opcode = op_jmp;
    fetch_to_dec("jmp");
    tick;
    checks++;
    if (!(bus.load_pc === 1'b1 && bus.pc_sel === 2'b10 && bus.addr2mux_sel === 2'b00 &&
          bus.addr1mux_sel === 1'b1)) begin
      errors++;
      $display("[TB] FAIL jmp load_pc=%b pc_sel=%b addr2=%b addr1=%b expected 1 10 00 1",
               bus.load_pc, bus.pc_sel, bus.addr2mux_sel, bus.addr1mux_sel);
    end
    tick;
    expect_f1("jmp");
  endtask

  task automatic test_ldr;
    int oe_cycles;
    bus.opcode = op_ldr;
    fetch_to_dec("ldr");
    tick;
    checks++;
    if (!(bus.GateMARMUX === 1'b1 && bus.addr2mux_sel === 2'b01 && bus.addr1mux_sel === 1'b1 &&
          bus.load_mar === 1'b1 && gate_count() == 1)) begin
      errors++;
      $display("[TB] FAIL ldr_ld1 GateMARMUX=%b addr2=%b addr1=%b load_mar=%b expected 1 01 1 1",
               bus.GateMARMUX, bus.addr2mux_sel, bus.addr1mux_sel, bus.load_mar);
    end
    tick;
    oe_cycles = 0;
    while (bus.Mem_OE === 1'b0 && oe_cycles < 20) begin
      oe_cycles++;
      tick;
    end
    checks++;
    if (oe_cycles != MW) begin
      errors++;
      $display("[TB] FAIL ldr_oe_cycles got %0d expected %0d", oe_cycles, MW);
    end
    checks++;
    if (!(bus.GateMDR === 1'b1 && bus.ld_reg === 1'b1 && gate_count() == 1)) begin
      errors++;
      $display("[TB] FAIL ldr_ld3 GateMDR=%b ld_reg=%b expected 1 1", bus.GateMDR, bus.ld_reg);
    end
    tick;
    expect_f1("ldr");
  endtask

  task automatic test_str;
    int we_cycles;
    bus.opcode = op_str;
    fetch_to_dec("str");
    tick;
    checks++;
    if (!(bus.GateMARMUX === 1'b1 && bus.addr2mux_sel === 2'b01 && bus.load_mar === 1'b1)) begin
      errors++;
      $display("[TB] FAIL str_st1 GateMARMUX=%b addr2=%b load_mar=%b expected 1 01 1",
               bus.GateMARMUX, bus.addr2mux_sel, bus.load_mar);
    end
    tick;
    checks++;
    if (!(bus.sr1_sel === 1'b1 && bus.ALUK === 2'b11 && bus.GateALU === 1'b1 &&
          bus.load_mdr === 1'b1 && gate_count() == 1 && bus.Mem_WE === 1'b1)) begin
      errors++;
      $display("[TB] FAIL str_st2 sr1_sel=%b ALUK=%b GateALU=%b load_mdr=%b gates=%0d expected 1 11 1 1 1",
               bus.sr1_sel, bus.ALUK, bus.GateALU, bus.load_mdr, gate_count());
    end
    tick;
    we_cycles = 0;
    while (bus.Mem_WE === 1'b0 && we_cycles < 20) begin
      if (bus.GateMDR !== 1'b1 || gate_count() != 1 || bus.Mem_CE !== 1'b0) begin
        checks++;
        errors++;
        $display("[TB] FAIL str_st3 GateMDR=%b gates=%0d CE=%b expected 1 1 0",
                 bus.GateMDR, gate_count(), bus.Mem_CE);
      end
      we_cycles++;
      tick;
    end
    checks++;
    if (we_cycles != MW) begin
      errors++;
      $display("[TB] FAIL str_we_cycles got %0d expected %0d", we_cycles, MW);
    end
    expect_f1("str");
  endtask

  task automatic test_pause;
    bus.opcode = op_pse;
    fetch_to_dec("pse");
`ifdef SLC3_PAUSE_EN
    bus.Continue = 1'b1;
    tick;
    checks++;
    if (dut.state_q !== PSE1) begin
      errors++;
      $display("[TB] FAIL pse_enter state=%0d expected %0d", dut.state_q, PSE1);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (dut.state_q !== PSE2 || load_count() != 0 || gate_count() != 0) begin
        errors++;
        $display("[TB] FAIL pse_hold cycle %0d state=%0d loads=%0d expected %0d 0",
                 i, dut.state_q, load_count(), PSE2);
      end
    end
    bus.Continue = 1'b0;
    tick;
    expect_f1("pse_resume");
`else
    bus.Continue = 1'b1;
    tick;
    bus.Continue = 1'b0;
    expect_f1("pse_nop");
`endif
  endtask

  task automatic test_reset_mid_store;
    bus.opcode = op_str;
    fetch_to_dec("rst_str");
    tick;
    tick;
    tick;
    checks++;
    if (bus.Mem_WE !== 1'b0 || dut.state_q !== ST3) begin
      errors++;
      $display("[TB] FAIL rst_str_in_st3 WE=%b state=%0d expected 0 %0d", bus.Mem_WE, dut.state_q, ST3);
    end
    Reset = 1'b0;
    tick;
    Reset = 1'b1;
    checks++;
    if (bus.Mem_WE !== 1'b1 || bus.Mem_CE !== 1'b1 || load_count() != 0 || gate_count() != 0 ||
        dut.state_q !== S_HALT) begin
      errors++;
      $display("[TB] FAIL rst_str_abort WE=%b CE=%b loads=%0d gates=%0d state=%0d expected 1 1 0 0 0",
               bus.Mem_WE, bus.Mem_CE, load_count(), gate_count(), dut.state_q);
    end
    tick;
    checks++;
    if (dut.state_q !== S_HALT) begin
      errors++;
      $display("[TB] FAIL rst_str_halt_hold state=%0d expected %0d", dut.state_q, S_HALT);
    end
    bus.Run = 1'b1;
    tick;
    bus.Run = 1'b0;
    expect_f1("rst_str_run");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b0;
    bus.Run = 1'b0;
    bus.Continue = 1'b0;
    bus.opcode = op_add;
    bus.BEN = 1'b0;
    bus.imm5_sel = 1'b0;
    tick;
    test_reset;
    test_alu;
    test_branch;
    test_ldr;
    test_str;
    test_pause;
    test_reset_mid_store;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
